adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 5-bit add-with-carry datapath (sum = A + B + c_in, 6-bit result) between `NUM_REQ` requesters. It accepts one operand set at a time over a valid/ready handshake and computes the sum in a registered stage. It returns the result, tagged with the requester index, on a single response channel that supports backpressure. It sits between the client blocks and the shared adder so that only one adder instance is needed.

---
 rtl/adder_share_arbiter.sv | 118 +++++++++++
 tb/tb_adder_share_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one registered add-with-carry stage
// between NUM_REQ requesters and returns id-tagged results on one channel.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_last_grant;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [IDW-1:0]     r_id;

  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_idx;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_cin;
  logic [NUM_REQ-1:0] w_onehot;

  // Scan from farthest to nearest so the last hit is the first after last_grant.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_last_grant) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_a      = '0;
    w_b      = '0;
    w_cin    = 1'b0;
    w_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner == IDW'(k)) begin
        w_a         = req_a[k*WIDTH +: WIDTH];
        w_b         = req_b[k*WIDTH +: WIDTH];
        w_cin       = req_cin[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // Gated by rst so no grant is advertised while the FSM is held in reset.
  assign req_ready = (!rst && r_state == S_IDLE && w_found) ? w_onehot : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_id         <= '0;
      rsp_valid    <= 1'b0;
      rsp_sum      <= '0;
      rsp_id       <= '0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a          <= w_a;
            r_b          <= w_b;
            r_cin        <= w_cin;
            r_id         <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= S_CALC;
            busy         <= 1'b1;
          end
        end
        S_CALC: begin
          rsp_sum   <= {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: latency, arbitration order,
// backpressure hold, mid-operation reset and operand capture.
module tb_adder_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 5;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH:0]           rsp_sum;
  logic [1:0]               rsp_id;
  logic                     busy;

  int n_vec = 0;
  int n_err = 0;

  // Operands used whenever all four requesters are active; sums hand-computed.
  int rr_a   [4] = '{1, 8, 15, 22};
  int rr_b   [4] = '{10, 3, 30, 31};
  int rr_c   [4] = '{0, 1, 1, 0};
  int rr_sum [4] = '{11, 12, 46, 53};
  int rr_ord [5] = '{0, 1, 2, 3, 0};

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input int a, input int b, input int c);
    req_a[i*WIDTH +: WIDTH] = a[WIDTH-1:0];
    req_b[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
    req_cin[i]              = c[0];
    req_valid[i]            = 1'b1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Single-requester transaction with exact latency checks; starts in IDLE.
  task automatic do_op(input string tag, input int id, input int a, input int b,
                       input int c, input int exp_sum);
    req_valid = '0;
    set_req(id, a, b, c);
    #1;
    check_val({tag, "_ready"}, req_ready, 32'(1 << id));
    step();
    req_valid = '0;
    check_val({tag, "_calc_valid"}, rsp_valid, 0);
    check_val({tag, "_busy"}, busy, 1);
    step();
    check_val({tag, "_valid"}, rsp_valid, 1);
    check_val({tag, "_sum"}, rsp_sum, exp_sum);
    check_val({tag, "_id"}, rsp_id, id);
    step();
    check_val({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;

    // reset values
    rst = 1'b1;
    step();
    step();
    check_val("rst_valid", rsp_valid, 0);
    check_val("rst_sum", rsp_sum, 0);
    check_val("rst_id", rsp_id, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;

    do_op("single", 2, 5, 9, 1, 15);
    do_op("max", 0, 31, 31, 1, 63);
    do_op("zero", 3, 0, 0, 0, 0);

    // round robin from reset, all requesters continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i], rr_c[i]);
    #1;
    for (int g = 0; g < 5; g++) begin
      check_val($sformatf("rr%0d_ready", g), req_ready, 32'(1 << rr_ord[g]));
      step();
      check_val($sformatf("rr%0d_calc_ready", g), req_ready, 0);
      step();
      check_val($sformatf("rr%0d_valid", g), rsp_valid, 1);
      check_val($sformatf("rr%0d_id", g), rsp_id, rr_ord[g]);
      check_val($sformatf("rr%0d_sum", g), rsp_sum, rr_sum[rr_ord[g]]);
      step();
    end
    req_valid = '0;

    // backpressure: five stalled cycles, handshake on the sixth
    rsp_ready = 1'b0;
    set_req(1, 10, 12, 0);
    #1;
    check_val("bp_accept", req_ready, 4'b0010);
    step();
    for (int i = 0; i < 4; i++) if (i != 1) set_req(i, rr_a[i], rr_b[i], rr_c[i]);
    #1;
    check_val("bp_calc_ready", req_ready, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      check_val($sformatf("bp%0d_valid", c), rsp_valid, 1);
      check_val($sformatf("bp%0d_sum", c), rsp_sum, 22);
      check_val($sformatf("bp%0d_id", c), rsp_id, 1);
      check_val($sformatf("bp%0d_ready", c), req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    check_val("bp_hs_valid", rsp_valid, 1);
    step();
    check_val("bp_idle_valid", rsp_valid, 0);
    check_val("bp_idle_busy", busy, 0);
    check_val("bp_idle_ready", req_ready, 4'b0100);
    req_valid = '0;

    // reset during CALC discards the in-flight transaction
    for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i], rr_c[i]);
    #1;
    check_val("mr_accept", req_ready, 4'b0100);
    step();
    check_val("mr_calc_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_val("mr_rst_valid", rsp_valid, 0);
    check_val("mr_rst_busy", busy, 0);
    check_val("mr_rst_ready", req_ready, 0);
    step();
    step();
    check_val("mr_rst_noresp", rsp_valid, 0);
    rst = 1'b0;
    #1;
    check_val("mr_after_ready", req_ready, 4'b0001);
    step();
    step();
    check_val("mr_after_valid", rsp_valid, 1);
    check_val("mr_after_id", rsp_id, 0);
    check_val("mr_after_sum", rsp_sum, 11);
    step();
    req_valid = '0;

    // operand change after accept must not affect the result
    set_req(1, 3, 4, 0);
    #1;
    check_val("oc_accept", req_ready, 4'b0010);
    step();
    req_a[1*WIDTH +: WIDTH] = 5'd20;
    req_valid = '0;
    step();
    check_val("oc_valid", rsp_valid, 1);
    check_val("oc_sum", rsp_sum, 7);
    check_val("oc_id", rsp_id, 1);
    step();
    check_val("oc_done", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
